// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for the scoreboarded register file.
// The master side is the pipeline (drives addresses and writes); the slave side is the register file.
interface regfile_scoreboard_if #(
   parameter int DW    = 32,
   parameter int NREGS = 16,
   parameter int AW    = 4
);
   logic [AW-1:0]    rs1;
   logic [AW-1:0]    rs2;
   logic [DW-1:0]    rd1;
   logic [DW-1:0]    rd2;
   logic             rd1_busy;
   logic             rd2_busy;
   logic             isWb;
   logic [AW-1:0]    wb_addr;
   logic [DW-1:0]    wb_data;
   logic             ra_en;
   logic [DW-1:0]    ra_data;
   logic             rsv_en;
   logic [AW-1:0]    rsv_addr;
   logic [NREGS-1:0] busy_vec;

   modport master (
      output rs1, rs2, isWb, wb_addr, wb_data, ra_en, ra_data, rsv_en, rsv_addr,
      input  rd1, rd2, rd1_busy, rd2_busy, busy_vec
   );

   modport slave (
      input  rs1, rs2, isWb, wb_addr, wb_data, ra_en, ra_data, rsv_en, rsv_addr,
      output rd1, rd2, rd1_busy, rd2_busy, busy_vec
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with a link write port, optional write-through bypass,
// optional hard-wired zero register and a per-register busy scoreboard for RAW stalls.
module regfile_scoreboard #(
   parameter int DW       = 32,
   parameter int NREGS    = 16,
   parameter int AW       = 4,
   parameter int RA_IDX   = 15,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input logic                clk,
   input logic                rst,
   regfile_scoreboard_if.slave bus
);
   localparam logic [AW-1:0] RA_ADDR = AW'(RA_IDX);

   logic [DW-1:0]    regs_q [NREGS];
   logic [DW-1:0]    regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [NREGS-1:0] release_vec;
   logic             wb_ok;
   logic             ra_ok;
   logic [DW-1:0]    rd1_val;
   logic [DW-1:0]    rd2_val;
   logic             rd1_busy_val;
   logic             rd2_busy_val;

   // Writes aimed at a hard-wired zero register are dropped before they reach any state.
   always_comb begin
      wb_ok = bus.isWb;
      ra_ok = bus.ra_en;
      if (ZERO_REG != 0) begin
         if (bus.wb_addr == '0) wb_ok = 1'b0;
         if (RA_ADDR == '0)     ra_ok = 1'b0;
      end
   end

   always_comb begin
      regs_d = regs_q;
      if (ra_ok) regs_d[RA_ADDR] = bus.ra_data;
      if (wb_ok) regs_d[bus.wb_addr] = bus.wb_data;
   end

   // A reserve in the same cycle as a release keeps the bit set: the newly issued instruction owns it.
   always_comb begin
      release_vec = '0;
      busy_d      = '0;
      for (int i = 0; i < NREGS; i++) begin
         release_vec[i] = (wb_ok && bus.wb_addr == AW'(i)) || (ra_ok && RA_ADDR == AW'(i));
         busy_d[i]      = (bus.rsv_en && bus.rsv_addr == AW'(i)) || (busy_q[i] && !release_vec[i]);
      end
      if (ZERO_REG != 0) busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         busy_q <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
         busy_q <= busy_d;
      end
   end

   // Bypass priority is writeback over link over stored value; busy never looks at rsv_en.
   always_comb begin
      rd1_val      = regs_q[bus.rs1];
      rd2_val      = regs_q[bus.rs2];
      rd1_busy_val = busy_q[bus.rs1];
      rd2_busy_val = busy_q[bus.rs2];
      if (BYPASS != 0) begin
         if (ra_ok && bus.rs1 == RA_ADDR)     rd1_val = bus.ra_data;
         if (wb_ok && bus.rs1 == bus.wb_addr) rd1_val = bus.wb_data;
         if (ra_ok && bus.rs2 == RA_ADDR)     rd2_val = bus.ra_data;
         if (wb_ok && bus.rs2 == bus.wb_addr) rd2_val = bus.wb_data;
         if (release_vec[bus.rs1]) rd1_busy_val = 1'b0;
         if (release_vec[bus.rs2]) rd2_busy_val = 1'b0;
      end
      if (ZERO_REG != 0) begin
         if (bus.rs1 == '0) begin
            rd1_val      = '0;
            rd1_busy_val = 1'b0;
         end
         if (bus.rs2 == '0) begin
            rd2_val      = '0;
            rd2_busy_val = 1'b0;
         end
      end
   end

   assign bus.rd1      = rd1_val;
   assign bus.rd2      = rd2_val;
   assign bus.rd1_busy = rd1_busy_val;
   assign bus.rd2_busy = rd2_busy_val;
   assign bus.busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench driving three register-file variants in lockstep:
// bypass enabled (u_dut), bypass disabled (u_nobyp) and zero register enabled (u_zero).
module tb_regfile_scoreboard;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   regfile_scoreboard_if #(.DW(32), .NREGS(16), .AW(4)) bus_a ();
   regfile_scoreboard_if #(.DW(32), .NREGS(16), .AW(4)) bus_b ();
   regfile_scoreboard_if #(.DW(32), .NREGS(16), .AW(4)) bus_c ();

   regfile_scoreboard #(.DW(32), .NREGS(16), .AW(4), .RA_IDX(15), .BYPASS(1), .ZERO_REG(0))
      u_dut (.clk(clk), .rst(rst), .bus(bus_a));
   regfile_scoreboard #(.DW(32), .NREGS(16), .AW(4), .RA_IDX(15), .BYPASS(0), .ZERO_REG(0))
      u_nobyp (.clk(clk), .rst(rst), .bus(bus_b));
   regfile_scoreboard #(.DW(32), .NREGS(16), .AW(4), .RA_IDX(15), .BYPASS(1), .ZERO_REG(1))
      u_zero (.clk(clk), .rst(rst), .bus(bus_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison in the bench funnels through here so the counts stay honest.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(
      input logic        wb_en, input logic [3:0] wb_a, input logic [31:0] wb_d,
      input logic        ra_e,  input logic [31:0] ra_d,
      input logic        rsv_e, input logic [3:0] rsv_a,
      input logic [3:0]  r1,    input logic [3:0] r2
   );
      bus_a.isWb = wb_en; bus_a.wb_addr = wb_a; bus_a.wb_data = wb_d;
      bus_a.ra_en = ra_e; bus_a.ra_data = ra_d; bus_a.rsv_en = rsv_e; bus_a.rsv_addr = rsv_a;
      bus_a.rs1 = r1; bus_a.rs2 = r2;
      bus_b.isWb = wb_en; bus_b.wb_addr = wb_a; bus_b.wb_data = wb_d;
      bus_b.ra_en = ra_e; bus_b.ra_data = ra_d; bus_b.rsv_en = rsv_e; bus_b.rsv_addr = rsv_a;
      bus_b.rs1 = r1; bus_b.rs2 = r2;
      bus_c.isWb = wb_en; bus_c.wb_addr = wb_a; bus_c.wb_data = wb_d;
      bus_c.ra_en = ra_e; bus_c.ra_data = ra_d; bus_c.rsv_en = rsv_e; bus_c.rsv_addr = rsv_a;
      bus_c.rs1 = r1; bus_c.rs2 = r2;
      #1;
   endtask

   task automatic idle(input logic [3:0] r1, input logic [3:0] r2);
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, r1, r2);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      idle(4'd0, 4'd0);
      tick();
      tick();
      rst = 1'b0;
      idle(4'd3, 4'd0);
      checkOutput("reset_rd1", bus_a.rd1, 64'h0);
      checkOutput("reset_busy_vec", bus_a.busy_vec, 64'h0);

      // Preload r3, then reset while writing and reserving it
      applyStimulus(1'b1, 4'd3, 32'h7, 1'b0, 32'h0, 1'b0, 4'd0, 4'd3, 4'd0);
      tick();
      idle(4'd3, 4'd0);
      checkOutput("preload_r3", bus_a.rd1, 64'h7);
      rst = 1'b1;
      applyStimulus(1'b1, 4'd3, 32'h9, 1'b0, 32'h0, 1'b1, 4'd3, 4'd3, 4'd0);
      tick();
      rst = 1'b0;
      idle(4'd3, 4'd3);
      checkOutput("rst_over_wb_rd1", bus_a.rd1, 64'h0);
      checkOutput("rst_over_rsv_busy_vec", bus_a.busy_vec, 64'h0);
      checkOutput("rst_rd1_busy", bus_a.rd1_busy, 64'h0);

      // Same-cycle bypass vs. registered read
      applyStimulus(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 4'd0, 4'd5, 4'd0);
      checkOutput("bypass_rd1", bus_a.rd1, 64'hDEADBEEF);
      checkOutput("nobypass_old_rd1", bus_b.rd1, 64'h0);
      tick();
      idle(4'd5, 4'd0);
      checkOutput("nobypass_new_rd1", bus_b.rd1, 64'hDEADBEEF);

      // Writeback and link to the same register: writeback wins
      applyStimulus(1'b1, 4'd15, 32'h11, 1'b1, 32'h40, 1'b0, 4'd0, 4'd15, 4'd0);
      checkOutput("collide_bypass_r15", bus_a.rd1, 64'h11);
      tick();
      idle(4'd15, 4'd0);
      checkOutput("collide_r15", bus_a.rd1, 64'h11);
      checkOutput("collide_r15_nobyp", bus_b.rd1, 64'h11);

      // Writeback and link to different registers: both land
      applyStimulus(1'b1, 4'd2, 32'h11, 1'b1, 32'h40, 1'b0, 4'd0, 4'd15, 4'd2);
      checkOutput("split_bypass_r15", bus_a.rd1, 64'h40);
      checkOutput("split_bypass_r2", bus_a.rd2, 64'h11);
      tick();
      idle(4'd2, 4'd15);
      checkOutput("split_r2", bus_a.rd1, 64'h11);
      checkOutput("split_r15", bus_a.rd2, 64'h40);
      checkOutput("release_idle_busy_vec", bus_a.busy_vec, 64'h0);

      // Reserve r7: not visible same cycle, busy afterwards until released
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b1, 4'd7, 4'd0, 4'd7);
      checkOutput("rsv_no_self_stall", bus_a.rd2_busy, 64'h0);
      checkOutput("rsv_busy_vec_pre", bus_a.busy_vec, 64'h0);
      tick();
      idle(4'd0, 4'd7);
      checkOutput("rsv_busy_vec", bus_a.busy_vec, 64'h0080);
      checkOutput("rsv_rd2_busy", bus_a.rd2_busy, 64'h1);
      checkOutput("rsv_rd2_busy_nobyp", bus_b.rd2_busy, 64'h1);
      tick();
      checkOutput("rsv_hold_rd2_busy", bus_a.rd2_busy, 64'h1);
      applyStimulus(1'b1, 4'd7, 32'h77, 1'b0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd7);
      checkOutput("release_bypass_rd2_busy", bus_a.rd2_busy, 64'h0);
      checkOutput("release_nobyp_rd2_busy", bus_b.rd2_busy, 64'h1);
      checkOutput("release_busy_vec_pre", bus_a.busy_vec, 64'h0080);
      tick();
      idle(4'd0, 4'd7);
      checkOutput("release_busy_vec", bus_a.busy_vec, 64'h0);
      checkOutput("release_rd2_busy_nobyp", bus_b.rd2_busy, 64'h0);

      // Reserve and release of r4 in the same cycle: reserve wins
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b1, 4'd4, 4'd4, 4'd0);
      tick();
      applyStimulus(1'b1, 4'd4, 32'h22, 1'b0, 32'h0, 1'b1, 4'd4, 4'd4, 4'd0);
      checkOutput("setclr_bypass_rd1_busy", bus_a.rd1_busy, 64'h0);
      tick();
      idle(4'd4, 4'd0);
      checkOutput("setclr_rd1", bus_a.rd1, 64'h22);
      checkOutput("setclr_busy_vec", bus_a.busy_vec, 64'h0010);
      checkOutput("setclr_rd1_busy", bus_a.rd1_busy, 64'h1);
      applyStimulus(1'b1, 4'd4, 32'h23, 1'b0, 32'h0, 1'b0, 4'd0, 4'd4, 4'd0);
      tick();
      idle(4'd4, 4'd0);
      checkOutput("setclr_final_busy_vec", bus_a.busy_vec, 64'h0);

      // Double reserve of r9 is cleared by a single release
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b1, 4'd9, 4'd9, 4'd0);
      tick();
      tick();
      idle(4'd9, 4'd0);
      checkOutput("double_rsv_busy_vec", bus_a.busy_vec, 64'h0200);
      applyStimulus(1'b1, 4'd9, 32'h99, 1'b0, 32'h0, 1'b0, 4'd0, 4'd9, 4'd0);
      tick();
      idle(4'd9, 4'd0);
      checkOutput("double_rsv_release", bus_a.busy_vec, 64'h0);

      // Link write releases the return-address register
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b1, 4'd15, 4'd15, 4'd0);
      tick();
      idle(4'd15, 4'd0);
      checkOutput("link_rsv_busy_vec", bus_a.busy_vec, 64'h8000);
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 32'h1234, 1'b0, 4'd0, 4'd15, 4'd0);
      checkOutput("link_bypass_rd1_busy", bus_a.rd1_busy, 64'h0);
      tick();
      idle(4'd15, 4'd0);
      checkOutput("link_release_busy_vec", bus_a.busy_vec, 64'h0);
      checkOutput("link_rd1", bus_a.rd1, 64'h1234);

      // Zero register: writes, bypass and reservations of r0 are ignored
      applyStimulus(1'b1, 4'd0, 32'h55, 1'b0, 32'h0, 1'b1, 4'd0, 4'd0, 4'd0);
      checkOutput("zero_bypass_rd1", bus_c.rd1, 64'h0);
      checkOutput("nonzero_bypass_rd1", bus_a.rd1, 64'h55);
      tick();
      idle(4'd0, 4'd0);
      checkOutput("zero_rd1", bus_c.rd1, 64'h0);
      checkOutput("zero_busy_vec", bus_c.busy_vec, 64'h0);
      checkOutput("zero_rd1_busy", bus_c.rd1_busy, 64'h0);
      checkOutput("nonzero_r0", bus_a.rd1, 64'h55);
      checkOutput("nonzero_busy_vec", bus_a.busy_vec, 64'h0001);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the 16x32 SimpleRISC register file. Provides clocked writes, synchronous reset, optional write-through bypass and optional hard-wired zero register.
- Adds a dedicated return-address (link) write port for call instructions.
- Adds a per-register busy scoreboard: decode reserves destinations and writeback releases them, so hazard logic can stall on RAW dependences.
- Sits between decode (read/reserve) and writeback (write/release).

Parameters:
- DW, 32, data width in bits.
- NREGS, 16, number of registers (power of two, >=4).
- AW, 4, address width; must equal log2(NREGS).
- RA_IDX, 15, index written by the link port.
- BYPASS, 1, 1 = same-cycle write data and release are visible on read ports.
- ZERO_REG, 0, 1 = register 0 reads 0, ignores writes, never busy.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- rs1  in  AW  read address port 1
- rs2  in  AW  read address port 2
- rd1  out  DW  read data port 1 (combinational)
- rd2  out  DW  read data port 2 (combinational)
- rd1_busy  out  1  register rs1 has an outstanding reservation
- rd2_busy  out  1  register rs2 has an outstanding reservation
- isWb  in  1  writeback enable
- wb_addr  in  AW  writeback destination
- wb_data  in  DW  writeback data
- ra_en  in  1  link write enable (call)
- ra_data  in  DW  return address to write into RA_IDX
- rsv_en  in  1  reserve destination (instruction issued)
- rsv_addr  in  AW  register to mark busy
- busy_vec  out  NREGS  registered scoreboard, bit i = register i busy

Behaviour:
- Reset: one clock is clock, one reset is synchronous active-high (rst sampled on rising edge of clk).
  - On rst=1 at a clock edge, all registers become 0 and busy_vec becomes 0.
  - Reset overrides every simultaneous write, link and reserve.
  - After reset, rd1/rd2 read 0 and rd1_busy/rd2_busy read 0.
- Writes (rising edge only, no latch behaviour):
  - isWb=1: reg[wb_addr] <= wb_data.
  - ra_en=1: reg[RA_IDX] <= ra_data.
  - Both enabled with wb_addr==RA_IDX: wb_data wins.
  - Both enabled to different addresses: both writes happen.
- Reads, BYPASS=0: rdN = reg[rsN]; a value written at edge k is visible after edge k.
- Reads, BYPASS=1: rdN returns the incoming write data when rsN matches an active write in the same cycle.
  - Priority: isWb match, then ra_en match, then the stored value.
  - Read latency from write acceptance is 0 cycles.
- Scoreboard, per register:
  - Set when rsv_en && rsv_addr==i.
  - Cleared when (isWb && wb_addr==i) or (ra_en && RA_IDX==i).
  - Set and clear to the same register in the same cycle: the set wins and the bit remains 1 (the new instruction owns it).
  - Release of a non-busy register is harmless; the bit stays 0.
  - Reserve of an already-busy register keeps it busy; there is no counting, one release clears it.
- rdN_busy:
  - BYPASS=0: busy_vec[rsN].
  - BYPASS=1: busy_vec[rsN] AND NOT (same-cycle release of rsN).
  - Never depends on same-cycle rsv_en, so a decode cannot self-stall.
- ZERO_REG=1:
  - Address 0 always reads 0, with no bypass.
  - Writes and link writes to 0 are dropped.
  - Reservations of 0 are ignored; busy_vec[0] is always 0.
- All address inputs are full-range; there are no out-of-range cases because NREGS = 2^AW.

Test Plan:
- Reset: preload r3=7 via isWb, assert rst for 1 cycle while isWb writes r3=9 -> rd1(rs1=3)=0, busy_vec=0 after the edge.
- Write/bypass: BYPASS=1, isWb=1, wb_addr=5, wb_data=0xDEADBEEF, rs1=5 in the same cycle -> rd1=0xDEADBEEF before the edge. BYPASS=0 -> rd1 = old value until after the edge.
- Link collision: isWb to r15 with 0x11, ra_en with ra_data=0x40 in the same cycle -> r15=0x11. Repeat with wb_addr=2 -> r2=0x11, r15=0x40.
- Scoreboard: rsv r7 at cycle 1 -> busy_vec[7]=1 and rd2_busy(rs2=7)=1 from cycle 2. isWb r7 at cycle 4 -> rd2_busy=0 in cycle 4 (BYPASS=1), busy_vec[7]=0 after the edge.
- Simultaneous reserve/release: busy r4, then in one cycle rsv r4 and isWb r4=0x22 -> r4=0x22, busy_vec[4] stays 1.
- ZERO_REG=1: isWb r0=0x55 and rsv r0 -> rd1(rs1=0)=0, busy_vec[0]=0.
